// File: rtl/rpn_stack_ctrl.sv
// Postfix token sequencer driving an external Stack: operands are pushed, and operators
// pop two entries, combine them and push the result. Overflow/underflow raise a sticky error.
module rpn_stack_ctrl #(
  parameter  int BANDWIDTH = 4,
  parameter  int DEPTH     = 8,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tok_valid,
  output logic                 tok_ready,
  input  logic                 tok_is_op,
  input  logic [BANDWIDTH-1:0] tok_data,
  output logic                 s_push,
  output logic                 s_pop,
  output logic [BANDWIDTH-1:0] s_data_in,
  input  logic [BANDWIDTH-1:0] s_data_out,
  input  logic                 s_full,
  input  logic                 s_empty,
  output logic                 res_valid,
  output logic [BANDWIDTH-1:0] res_data,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [2:0]           dbg_state,
  output logic [CW-1:0]        dbg_cnt
);

  // Token handshake: a token transfers on the rising edge where tok_valid && tok_ready;
  // tok_ready is high only in IDLE, and the token fields must be stable while tok_valid is high.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_OP = 3'd1,
    POP_B   = 3'd2,
    CAP_B   = 3'd3,
    POP_A   = 3'd4,
    CAP_A   = 3'd5,
    PUSH_R  = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [BANDWIDTH-1:0] r_b;
  logic [1:0]           r_op;
  logic                 r_s_push;
  logic                 r_s_pop;
  logic [BANDWIDTH-1:0] r_s_data_in;
  logic                 r_res_valid;
  logic [BANDWIDTH-1:0] r_res_data;
  logic                 r_err;
  logic [1:0]           r_err_code;

  logic                 w_accept;
  logic                 w_ovf;
  logic                 w_unf;
  logic [BANDWIDTH-1:0] w_a;
  logic [BANDWIDTH-1:0] w_alu;

  assign tok_ready = rstn && (r_state == IDLE);
  assign s_push    = r_s_push;
  assign s_pop     = r_s_pop;
  assign s_data_in = r_s_data_in;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign dbg_state = r_state;
  assign dbg_cnt   = r_cnt;

  // The deeper operand is consumed straight from the Stack in CAP_A, so the
  // result is ready to be registered on the same edge that captures it.
  assign w_a = s_data_out;

  always_comb begin
    w_alu = '0;
    case (r_op)
      2'b00:   w_alu = w_a + r_b;
      2'b01:   w_alu = w_a - r_b;
      2'b10:   w_alu = w_a & r_b;
      default: w_alu = w_a ^ r_b;
    endcase
  end

  always_comb begin
    w_accept = tok_valid && (r_state == IDLE);
    w_ovf    = w_accept && !tok_is_op && ((r_cnt == CW'(DEPTH)) || s_full);
    w_unf    = w_accept &&  tok_is_op && ((r_cnt < CW'(2)) || s_empty);
    w_next   = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !tok_is_op && !w_ovf) w_next = PUSH_OP;
        if (w_accept &&  tok_is_op && !w_unf) w_next = POP_B;
      end
      PUSH_OP: w_next = IDLE;
      POP_B:   w_next = CAP_B;
      CAP_B:   w_next = POP_A;
      POP_A:   w_next = CAP_A;
      CAP_A:   w_next = PUSH_R;
      PUSH_R:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_s_push    <= 1'b0;
      r_s_pop     <= 1'b0;
      r_s_data_in <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_state     <= w_next;
      r_s_push    <= (w_next == PUSH_OP) || (w_next == PUSH_R);
      r_s_pop     <= (w_next == POP_B) || (w_next == POP_A);
      r_res_valid <= (w_next == PUSH_R);
      if (w_next == PUSH_OP) r_s_data_in <= tok_data;
      if (w_next == PUSH_R) begin
        r_s_data_in <= w_alu;
        r_res_data  <= w_alu;
      end
      if (w_next == POP_B) r_op <= tok_data[1:0];
      if (r_state == CAP_B) r_b <= s_data_out;
      case ({r_s_push, r_s_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      // Only the first error is recorded; later ones leave the flag and code alone.
      if (!r_err && (w_ovf || w_unf)) begin
        r_err      <= 1'b1;
        r_err_code <= w_ovf ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl with a behavioural Stack attached to its Stack ports.
module tb_rpn_stack_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POP_A = 3'd4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tok_valid = 1'b0;
  logic       tok_ready;
  logic       tok_is_op = 1'b0;
  logic [3:0] tok_data = '0;
  logic       s_push, s_pop;
  logic [3:0] s_data_in;
  logic [3:0] s_data_out;
  logic       s_full, s_empty;
  logic       res_valid;
  logic [3:0] res_data;
  logic       err;
  logic [1:0] err_code;
  logic [2:0] dbg_state;
  logic [3:0] dbg_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int res_cyc = 0;
  int pop_n = 0;
  int both_n = 0;
  logic [3:0] push_q[$];
  logic [3:0] res_q[$];
  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rpn_stack_ctrl #(.BANDWIDTH(4), .DEPTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
    .s_push(s_push), .s_pop(s_pop), .s_data_in(s_data_in), .s_data_out(s_data_out),
    .s_full(s_full), .s_empty(s_empty),
    .res_valid(res_valid), .res_data(res_data), .err(err), .err_code(err_code),
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // ---------------- Stack model ----------------
  logic [3:0] mem [8];
  logic [3:0] sp;
  assign s_full  = (sp == 4'd8);
  assign s_empty = (sp == 4'd0);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sp         <= '0;
      s_data_out <= '0;
    end else if (s_push && sp < 4'd8) begin
      mem[sp[2:0]] <= s_data_in;
      sp           <= sp + 4'd1;
    end else if (s_pop && sp > 4'd0) begin
      s_data_out <= mem[sp[2:0] - 3'd1];
      sp         <= sp - 4'd1;
    end
  end

  // ---------------- bus monitor ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (s_push) push_q.push_back(s_data_in);
      if (s_pop) pop_n++;
      if (s_push && s_pop) both_n++;
      if (res_valid) begin
        res_q.push_back(res_data);
        res_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    push_q.delete();
    res_q.delete();
    exp_q.delete();
    pop_n = 0;
    both_n = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    tok_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    clear_logs();
  endtask

  task automatic send(input logic is_op, input logic [3:0] d);
    int n;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = d;
    n = 0;
    while (!tok_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: tok_ready stayed %0b, required 1", tok_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    tok_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %0b want 0", s_push); end
    checks++; if (s_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %0b want 0", s_pop); end
    checks++; if (s_data_in !== 4'h0) begin errors++; $display("FAIL reset_data_in: got %h want 0", s_data_in); end
    checks++; if (res_valid !== 1'b0 || res_data !== 4'h0) begin errors++; $display("FAIL reset_res: got %0b/%h want 0/0", res_valid, res_data); end
    checks++; if (err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL reset_err: got %0b/%b want 0/00", err, err_code); end
    checks++; if (dbg_cnt !== 4'd0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_fsm: got cnt %0d state %0d want 0/0", dbg_cnt, dbg_state); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (tok_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", tok_ready); end
    clear_logs();
  endtask

  task automatic test_add();
    do_reset();
    send(1'b0, 4'd3);
    send(1'b0, 4'd5);
    send(1'b1, 4'b0000);
    settle();
    exp_q = '{4'd3, 4'd5, 4'd8};
    checks++;
    if (push_q.size() != exp_q.size()) begin
      errors++; $display("FAIL add_push_count: got %0d want %0d", push_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (push_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL add_push_data[%0d]: got %h want %h", i, push_q[i], exp_q[i]);
        end
    end
    checks++; if (pop_n != 2) begin errors++; $display("FAIL add_pops: got %0d want 2", pop_n); end
    checks++; if (res_q.size() != 1 || res_q[0] !== 4'd8) begin errors++; $display("FAIL add_result: got %0d items first %h want 1 item 8", res_q.size(), (res_q.size() > 0) ? res_q[0] : 4'hx); end
    checks++; if (dbg_cnt !== 4'd1) begin errors++; $display("FAIL add_cnt: got %0d want 1", dbg_cnt); end
  endtask

  task automatic test_sub_xor();
    do_reset();
    send(1'b0, 4'd2);
    send(1'b0, 4'd7);
    send(1'b1, 4'b0001);
    send(1'b0, 4'd6);
    send(1'b0, 4'd3);
    send(1'b1, 4'b0011);
    settle();
    exp_q = '{4'hB, 4'h5};
    checks++;
    if (res_q.size() != exp_q.size()) begin
      errors++; $display("FAIL subxor_count: got %0d want %0d", res_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (res_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL subxor_result[%0d]: got %h want %h", i, res_q[i], exp_q[i]);
        end
    end
    checks++; if (dbg_cnt !== 4'd2) begin errors++; $display("FAIL subxor_cnt: got %0d want 2", dbg_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) send(1'b0, 4'(i));
    settle();
    checks++; if (dbg_cnt !== 4'd8 || err !== 1'b0) begin errors++; $display("FAIL ovf_fill: got cnt %0d err %0b want 8/0", dbg_cnt, err); end
    send(1'b0, 4'd9);
    settle();
    checks++; if (push_q.size() != 8) begin errors++; $display("FAIL ovf_pushes: got %0d want 8", push_q.size()); end
    checks++; if (err !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL ovf_err: got %0b/%b want 1/01", err, err_code); end
    checks++; if (dbg_cnt !== 4'd8) begin errors++; $display("FAIL ovf_cnt: got %0d want 8", dbg_cnt); end
  endtask

  task automatic test_underflow();
    do_reset();
    send(1'b1, 4'b0000);
    settle();
    checks++; if (pop_n != 0) begin errors++; $display("FAIL unf_pop: got %0d want 0", pop_n); end
    checks++; if (err !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL unf_err: got %0b/%b want 1/10", err, err_code); end
    send(1'b0, 4'd1);
    send(1'b1, 4'b0010);
    settle();
    checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL unf_sticky: got %b want 10", err_code); end
    checks++; if (pop_n != 0 || res_q.size() != 0) begin errors++; $display("FAIL unf_nopop: got pops %0d results %0d want 0/0", pop_n, res_q.size()); end
    checks++; if (dbg_cnt !== 4'd1 || push_q.size() != 1) begin errors++; $display("FAIL unf_cnt: got cnt %0d pushes %0d want 1/1", dbg_cnt, push_q.size()); end
  endtask

  task automatic test_back_to_back();
    int a0;
    int a2;
    do_reset();
    send(1'b0, 4'd4);
    a0 = acc_cyc;
    @(negedge clk);
    checks++; if (s_push !== 1'b1 || s_data_in !== 4'd4) begin errors++; $display("FAIL b2b_push_lat: got %0b/%h want 1/4", s_push, s_data_in); end
    send(1'b0, 4'd4);
    checks++; if (acc_cyc - a0 != 2) begin errors++; $display("FAIL b2b_operand_gap: got %0d want 2", acc_cyc - a0); end
    send(1'b1, 4'b0000);
    a2 = acc_cyc;
    send(1'b0, 4'd1);
    checks++; if (acc_cyc - a2 != 6) begin errors++; $display("FAIL b2b_operator_gap: got %0d want 6", acc_cyc - a2); end
    // res_valid occupies the fifth cycle after the accepting edge
    checks++; if (res_cyc - a2 != 4) begin errors++; $display("FAIL b2b_res_lat: got %0d want 4", res_cyc - a2); end
    checks++; if (res_q.size() != 1 || res_q[0] !== 4'd8) begin errors++; $display("FAIL b2b_result: got %0d items want one 8", res_q.size()); end
    settle();
    checks++; if (both_n != 0) begin errors++; $display("FAIL b2b_push_pop_overlap: got %0d want 0", both_n); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    send(1'b0, 4'd1);
    send(1'b0, 4'd2);
    send(1'b1, 4'b0000);
    n = 0;
    while (dbg_state !== ST_POP_A && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (dbg_state !== ST_POP_A || s_pop !== 1'b1) begin errors++; $display("FAIL mid_reach_pop_a: got state %0d pop %0b want 4/1", dbg_state, s_pop); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (s_pop !== 1'b0) begin errors++; $display("FAIL mid_pop_drop: got %0b want 0", s_pop); end
    checks++; if (dbg_cnt !== 4'd0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL mid_state: got cnt %0d state %0d want 0/0", dbg_cnt, dbg_state); end
    @(negedge clk);
    rstn = 1'b1;
    clear_logs();
    send(1'b0, 4'd4);
    send(1'b0, 4'd4);
    send(1'b1, 4'b0000);
    settle();
    checks++; if (res_q.size() != 1 || res_q[0] !== 4'd8) begin errors++; $display("FAIL mid_result: got %0d items want one 8", res_q.size()); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %0b want 0", err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub_xor();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
